// File: rtl/timer_pkg.sv
// Shared mode and channel-state encodings for the timer interrupt bank.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  localparam logic [31:0] DEFAULT_RESET_LOAD = 32'hEFFF_FFFF;

  // Only one-shot and periodic modes count; reserved behaves like off.
  function automatic logic mode_runs(input mode_e m);
    return (m == MODE_ONESHOT) || (m == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting interval timer with sticky pending and overrun flags.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [1:0]   wr_mode,
  input  logic [W-1:0] wr_val,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         pending,
  output logic         overrun
);

  chan_state_e  state;
  mode_e        mode;
  logic [W-1:0] reload;

  // Write beats everything; expiry-set beats the acknowledge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CH_IDLE;
      mode    <= MODE_OFF;
      count   <= RST_VAL;
      reload  <= RST_VAL;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (wr_en) begin
      count   <= wr_val;
      reload  <= wr_val;
      mode    <= mode_e'(wr_mode);
      pending <= 1'b0;
      overrun <= 1'b0;
      state   <= mode_runs(mode_e'(wr_mode)) ? CH_RUN : CH_IDLE;
    end else begin
      if (clr) begin
        pending <= 1'b0;
      end
      if (state == CH_RUN) begin
        if (count == '0) begin
          pending <= 1'b1;
          if (pending && !clr) begin
            overrun <= 1'b1;
          end
          if (mode == MODE_PERIODIC) begin
            count <= reload;
          end else begin
            state <= CH_IDLE;
          end
        end else begin
          count <= count - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_irq_bank.sv
// Bank of NCH interval timers with lowest-index interrupt arbitration and take/ack handshake.
module timer_irq_bank
  import timer_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned W          = 32,
  parameter logic [31:0] RESET_LOAD = DEFAULT_RESET_LOAD,
  parameter int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_sel,
  input  logic [1:0]     wr_mode,
  input  logic [W-1:0]   wr_val,
  input  logic [CW-1:0]  rd_sel,
  input  logic           irq_take,
  input  logic           irq_ack,
  output logic [W-1:0]   rd_val,
  output logic [NCH-1:0] irq_pending,
  output logic [NCH-1:0] overrun,
  output logic           irq_req,
  output logic [CW-1:0]  irq_id,
  output logic           in_service
);

  localparam logic [W-1:0] RST_VAL = W'(RESET_LOAD);

  logic [W-1:0]  counts [NCH];
  logic [CW-1:0] winner;
  logic [CW-1:0] id_q;
  logic          take_fire;
  logic          ack_fire;

  assign ack_fire  = irq_ack & in_service;
  assign take_fire = irq_take & irq_req;
  assign irq_req   = (|irq_pending) & ~in_service;
  assign irq_id    = in_service ? id_q : winner;

  // Channel instances; the ack clears only the channel being serviced.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_channel #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && (wr_sel == CW'(g))),
      .wr_mode (wr_mode),
      .wr_val  (wr_val),
      .clr     (ack_fire && (id_q == CW'(g))),
      .count   (counts[g]),
      .pending (irq_pending[g]),
      .overrun (overrun[g])
    );
  end

  // Lowest-index pending channel wins.
  always_comb begin
    winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (irq_pending[i]) begin
        winner = CW'(i);
      end
    end
  end

  // Live count read-back; out-of-range selects read zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == CW'(i)) begin
        rd_val = counts[i];
      end
    end
  end

  // Handshake: take latches the winner, ack retires it; ack dominates take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_service <= 1'b0;
      id_q       <= '0;
    end else if (ack_fire) begin
      in_service <= 1'b0;
    end else if (take_fire) begin
      in_service <= 1'b1;
      id_q       <= winner;
    end
  end

endmodule

// File: tb/tb_timer_irq_bank.sv
// Self-checking bench for timer_irq_bank: directed table, corner sequences, random vs model.
module tb_timer_irq_bank;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_mode;
  logic [31:0] wr_val;
  logic [1:0]  rd_sel;
  logic        irq_take;
  logic        irq_ack;
  logic [31:0] rd_val;
  logic [3:0]  irq_pending;
  logic [3:0]  overrun;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RL = 32'hEFFF_FFFF;

  timer_irq_bank dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_mode     (wr_mode),
    .wr_val      (wr_val),
    .rd_sel      (rd_sel),
    .irq_take    (irq_take),
    .irq_ack     (irq_ack),
    .rd_val      (rd_val),
    .irq_pending (irq_pending),
    .overrun     (overrun),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .in_service  (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: plain per-channel arrays.
  bit [31:0] m_cnt [4];
  bit [31:0] m_rel [4];
  bit [1:0]  m_mode [4];
  bit        m_run [4];
  bit [3:0]  m_pend;
  bit [3:0]  m_ovr;
  bit        m_insvc;
  bit [1:0]  m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] m_winner();
    bit [1:0] w = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) w = 2'(i);
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = RL; m_rel[c] = RL; m_mode[c] = 2'b00; m_run[c] = 1'b0;
    end
    m_pend = '0; m_ovr = '0; m_insvc = 1'b0; m_id = '0;
  endtask

  // One clock of behaviour, evaluated from the pre-edge state and inputs.
  task automatic model_step();
    bit [3:0] np = m_pend;
    bit [3:0] no = m_ovr;
    bit req = (m_pend != 0) && !m_insvc;
    bit ack_f = irq_ack && m_insvc;
    bit take_f = irq_take && req;
    bit [1:0] w = m_winner();
    for (int c = 0; c < 4; c++) begin
      bit clr = ack_f && (m_id == 2'(c));
      bit expired = 1'b0;
      if (m_run[c]) begin
        if (m_cnt[c] == 0) begin
          expired = 1'b1;
          if (m_mode[c] == 2'b10) m_cnt[c] = m_rel[c];
          else m_run[c] = 1'b0;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
      if (clr) np[c] = 1'b0;
      if (expired) begin
        if (m_pend[c] && !clr) no[c] = 1'b1;
        np[c] = 1'b1;
      end
      if (wr_en && wr_sel == 2'(c)) begin
        m_cnt[c] = wr_val; m_rel[c] = wr_val; m_mode[c] = wr_mode;
        m_run[c] = (wr_mode == 2'b01) || (wr_mode == 2'b10);
        np[c] = 1'b0; no[c] = 1'b0;
      end
    end
    m_pend = np; m_ovr = no;
    if (ack_f) m_insvc = 1'b0;
    else if (take_f) begin m_insvc = 1'b1; m_id = w; end
  endtask

  task automatic compare_model();
    check("pending", 32'(irq_pending), 32'(m_pend));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("irq_req", 32'(irq_req), 32'((m_pend != 0) && !m_insvc));
    check("irq_id", 32'(irq_id), 32'(m_insvc ? m_id : m_winner()));
    check("in_service", 32'(in_service), 32'(m_insvc));
    check("rd_val", rd_val, m_cnt[rd_sel]);
  endtask

  // Drive one cycle of inputs, clock, advance the model, compare.
  task automatic step(input bit we, input bit [1:0] sel, input bit [1:0] mode,
                      input bit [31:0] val, input bit [1:0] rs,
                      input bit take, input bit ack);
    wr_en = we; wr_sel = sel; wr_mode = mode; wr_val = val;
    rd_sel = rs; irq_take = take; irq_ack = ack;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle(input bit [1:0] rs);
    step(1'b0, 2'd0, 2'd0, 32'd0, rs, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wr_mode = '0; wr_val = '0;
    rd_sel = '0; irq_take = 1'b0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit        we;
    bit [1:0]  sel;
    bit [1:0]  mode;
    bit [31:0] val;
    bit [1:0]  rs;
    bit        take;
    bit        ack;
    bit [3:0]  e_pend;
    bit        e_req;
    bit [1:0]  e_id;
    bit        e_ins;
    bit [31:0] e_rd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Directed one-shot on channel 2 with full take/ack cycle.
    tbl[0] = '{1, 2, 2'b01, 3, 2, 0, 0, 4'b0000, 0, 0, 0, 3};
    tbl[1] = '{0, 0, 2'b00, 0, 2, 0, 0, 4'b0000, 0, 0, 0, 2};
    tbl[2] = '{0, 0, 2'b00, 0, 2, 0, 0, 4'b0000, 0, 0, 0, 1};
    tbl[3] = '{0, 0, 2'b00, 0, 2, 0, 0, 4'b0000, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 2'b00, 0, 2, 0, 0, 4'b0100, 1, 2, 0, 0};
    tbl[5] = '{0, 0, 2'b00, 0, 0, 0, 0, 4'b0100, 1, 2, 0, RL};
    tbl[6] = '{0, 0, 2'b00, 0, 2, 1, 0, 4'b0100, 0, 2, 1, 0};
    tbl[7] = '{0, 0, 2'b00, 0, 2, 0, 1, 4'b0000, 0, 0, 0, 0};

    reset = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wr_mode = '0; wr_val = '0;
    rd_sel = '0; irq_take = 1'b0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst pending", 32'(irq_pending), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst irq_req", 32'(irq_req), 0);
    check("rst irq_id", 32'(irq_id), 0);
    check("rst in_service", 32'(in_service), 0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("rst rd_val[%0d]", i), rd_val, RL);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].sel, tbl[i].mode, tbl[i].val, tbl[i].rs, tbl[i].take, tbl[i].ack);
      check($sformatf("tbl%0d pending", i), 32'(irq_pending), 32'(tbl[i].e_pend));
      check($sformatf("tbl%0d irq_req", i), 32'(irq_req), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d irq_id", i), 32'(irq_id), 32'(tbl[i].e_id));
      check($sformatf("tbl%0d in_service", i), 32'(in_service), 32'(tbl[i].e_ins));
      check($sformatf("tbl%0d rd_val", i), rd_val, tbl[i].e_rd);
    end

    // Periodic 5 on ch0 with no ack: pending at cycle 6, overrun at cycle 12.
    do_reset();
    step(1, 0, 2'b10, 5, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      idle(0);
      if (k == 5) check("per5 pend@5", 32'(irq_pending[0]), 0);
      if (k == 6) begin
        check("per5 pend@6", 32'(irq_pending[0]), 1);
        check("per5 ovr@6", 32'(overrun[0]), 0);
        check("per5 reload@6", rd_val, 5);
      end
      if (k == 11) check("per5 ovr@11", 32'(overrun[0]), 0);
      if (k == 12) check("per5 ovr@12", 32'(overrun[0]), 1);
    end

    // ch1 and ch3 expire together; lowest index first, then ch3 after ack.
    do_reset();
    step(1, 1, 2'b01, 3, 1, 0, 0);
    step(1, 3, 2'b01, 2, 3, 0, 0);
    idle(1);
    idle(1);
    idle(1);
    check("pair pending", 32'(irq_pending), 32'b1010);
    check("pair id", 32'(irq_id), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    check("pair take ins", 32'(in_service), 1);
    check("pair take id", 32'(irq_id), 1);
    check("pair take req", 32'(irq_req), 0);
    step(0, 0, 0, 0, 1, 0, 1);
    check("pair ack id", 32'(irq_id), 3);
    check("pair ack req", 32'(irq_req), 1);
    check("pair ack pending", 32'(irq_pending), 32'b1000);

    // Expiry coinciding with ack on the same channel.
    do_reset();
    step(1, 0, 2'b10, 1, 0, 0, 0);
    idle(0);
    idle(0);
    check("coinc pend", 32'(irq_pending[0]), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("coinc pend kept", 32'(irq_pending[0]), 1);
    check("coinc no ovr", 32'(overrun[0]), 0);
    check("coinc ins clr", 32'(in_service), 0);

    // Reload 0: expires every cycle, pending survives every ack.
    do_reset();
    step(1, 0, 2'b10, 0, 0, 0, 0);
    idle(0);
    check("zero pend lat1", 32'(irq_pending[0]), 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("zero pend after ack", 32'(irq_pending[0]), 1);
    end
    // Write on an expiring cycle wins.
    step(1, 0, 2'b00, 9, 0, 0, 0);
    check("wr wins pend", 32'(irq_pending[0]), 0);
    check("wr wins ovr", 32'(overrun[0]), 0);
    check("wr wins cnt", rd_val, 9);

    // Reset while in service and ch2 at count 7.
    do_reset();
    step(1, 2, 2'b01, 10, 2, 0, 0);
    step(1, 0, 2'b01, 0, 2, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 2, 1, 0);
    check("pre-rst ins", 32'(in_service), 1);
    check("pre-rst cnt", rd_val, 7);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async pending", 32'(irq_pending), 0);
    check("async req", 32'(irq_req), 0);
    check("async ins", 32'(in_service), 0);
    check("async id", 32'(irq_id), 0);
    check("async rd_val", rd_val, RL);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit [31:0] v;
      v = ($urandom % 8 == 0) ? $urandom : ($urandom % 10);
      step(($urandom % 6) == 0, 2'($urandom), 2'($urandom), v, 2'($urandom),
           ($urandom % 3) == 0, ($urandom % 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
